div_event_timer: RTL and testbench
==================================

# div_event_timer

Programmable event timer that sits directly downstream of `clock_divider`. It takes the divider's output `q` as `div_in`, which is a registered square wave in the `clk` domain. It converts each rising edge of `div_in` into a one-cycle `tick` and counts those ticks down from a loaded period, pulsing `done` when the count expires. It supports single-shot and auto-reload modes, restart and abort, which lets slow periodic events be timed in multiples of the divided clock without a second clock domain.

## Interface
- `WIDTH`, default 8: width of `period` and `remaining`.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `div_in`  in  1: divided-clock level from `clock_divider.q`, synchronous to `clk`.
- `start`  in  1: one-cycle request that loads `period` and begins counting.
- `stop`  in  1: abort the current run.
- `period`  in  WIDTH: number of `div_in` rising edges to count; sampled on `start` and on each auto-reload.
- `auto_reload`  in  1: 1 = periodic mode, 0 = single-shot; sampled at expiry.
- `tick`  out  1: one-cycle pulse per `div_in` rising edge, active in every state.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse on expiry.
- `remaining`  out  WIDTH: edges left in the current run; 0 when idle.

## Operation
- Edge detect:
  - `div_q` is updated with `div_in` every cycle.
  - `rise = div_in & ~div_q` (combinational).
  - During `rst`, `div_q` loads `div_in` so that no false edge is reported after reset.
- States: IDLE and RUN.
- Reset:
  - State goes to IDLE.
  - `tick`, `busy` and `done` are 0.
  - `remaining` is 0.
- IDLE:
  - If `start` and `period` != 0: `remaining` <= `period`, go to RUN.
  - If `start` and `period` == 0: `done` pulses, stay in IDLE.
  - `rise` events are ignored apart from driving `tick`.
- RUN, evaluated in priority order:
  1. `start`: `remaining` <= `period`, stay in RUN. Any `rise` in the same cycle is discarded (restart wins). `start` also beats `stop`.
  2. `stop`: go to IDLE, `remaining` <= 0, no `done` pulse.
  3. `rise` and `remaining` > 1: `remaining` <= `remaining` - 1.
  4. `rise` and `remaining` == 1: `done` pulses.
     - If `auto_reload` = 1 and `period` != 0: `remaining` <= `period`, stay in RUN.
     - Otherwise: `remaining` <= 0, go to IDLE.
- `busy` is 1 exactly when the state is RUN.
- `remaining` never wraps. A decrement below 1 is impossible by construction.
- Changes to `period` during a run take effect only at the next `start` or reload.

## Timing
- All outputs are registered with no combinational input-to-output paths.
- Event at edge k: `div_in` sampled 1 at clock edge k with `div_q` = 0 (i.e. `div_in` was sampled 0 at edge k-1).
  - `tick` is high for the single cycle after edge k.
  - `remaining` shows its new value in that same cycle.
  - `done` is high in that same cycle when the run expires.
- On single-shot expiry, `busy` falls in the same cycle that `done` rises.
- `start` sampled at edge k: `busy` = 1 and `remaining` = `period` from the cycle after edge k.
- `start` with `period` = 0: `done` is high for the cycle after edge k.
- `rst` asserted mid-run: IDLE with all outputs at their reset values from the next cycle, with no `done` pulse.
- Maximum `tick`/`done` rate is one pulse every 2 cycles, because `div_in` needs at least one low sample between edges.

## Test plan
- Reset with `div_in` = 1:
  - Stimulus: hold `rst` for 2 cycles with `div_in` held at 1, then release.
  - Required: `tick` = `busy` = `done` = 0 and `remaining` = 0, with no tick on the first cycle after release.
- Single-shot:
  - Stimulus: `div_in` square wave with an 8-cycle period (4 high, 4 low); `start` with `period` = 3 and `auto_reload` = 0.
  - Required: `remaining` steps 3→2→1→0, one step per tick.
  - Required: `done` is high for exactly 1 cycle, coincident with the 3rd tick after start, and `busy` falls in that cycle.
- Auto-reload:
  - Stimulus: `period` = 2, `auto_reload` = 1, same 8-cycle `div_in`.
  - Required: `done` every 16 cycles, `busy` stays 1, and `remaining` shows 2,1,2,1,…
- Zero period:
  - Stimulus: `start` with `period` = 0.
  - Required: `done` pulses once on the next cycle, `busy` stays 0, `remaining` stays 0.
- Restart, abort and priority:
  - `start` with `period` = 5 while `remaining` = 2 → `remaining` = 5 and the coincident rise is discarded.
  - `stop` in RUN → IDLE with no `done`.
  - `start` and `stop` together → restart.
- Reset mid-run:
  - Stimulus: assert `rst` while `remaining` = 4.
  - Required: next cycle `busy` = 0 and `remaining` = 0; no `done` at any later edge until a new `start`.

Source files
------------

// File: rtl/div_event_timer.sv
// div_event_timer: counts rising edges of a divided-clock level (div_in) down
// from a loaded period and pulses done on expiry. Supports single-shot and
// auto-reload modes, restart (start) and abort (stop). All outputs registered.
module div_event_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] period,
    input  logic             auto_reload,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic {StIdle, StRun} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             done_q, done_d;
    logic             tick_q;
    logic             div_q;
    logic             rise;

    assign rise = div_in & ~div_q;

    // Edge-detect history; tracks div_in during reset too so that a level held
    // high across reset release does not look like a fresh edge.
    always_ff @(posedge clk) begin
        div_q <= div_in;
    end

    // Next-state logic for the IDLE/RUN countdown.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (period != '0) begin
                        remaining_d = period;
                        state_d     = StRun;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (start) begin
                    // Restart wins over stop and over a coincident edge.
                    if (period != '0) begin
                        remaining_d = period;
                    end else begin
                        // A zero period cannot be counted; finish at once so
                        // remaining stays >= 1 whenever RUN is held.
                        done_d      = 1'b1;
                        remaining_d = '0;
                        state_d     = StIdle;
                    end
                end else if (stop) begin
                    remaining_d = '0;
                    state_d     = StIdle;
                end else if (rise) begin
                    if (remaining_q > WIDTH'(1)) begin
                        remaining_d = remaining_q - WIDTH'(1);
                    end else begin
                        done_d = 1'b1;
                        if (auto_reload && (period != '0)) begin
                            remaining_d = period;
                        end else begin
                            remaining_d = '0;
                            state_d     = StIdle;
                        end
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                remaining_d = '0;
            end
        endcase
    end

    // State, count and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            done_q      <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            tick_q      <= rise;
        end
    end

    assign tick      = tick_q;
    assign busy      = (state_q == StRun);
    assign done      = done_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_div_event_timer.sv
// Self-checking bench for div_event_timer: a cycle-by-cycle vector table plus
// hand-written square-wave sequences for single-shot, auto-reload and reset.
module tb_div_event_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       div_in = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] period = 8'd0;
    logic       auto_reload = 1'b0;
    logic       tick;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    int checks = 0;
    int failures = 0;

    div_event_timer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_in     (div_in),
        .start      (start),
        .stop       (stop),
        .period     (period),
        .auto_reload(auto_reload),
        .tick       (tick),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       div;
        logic       start;
        logic       stop;
        logic [7:0] per;
        logic       ar;
        logic       tick;
        logic       busy;
        logic       done;
        logic [7:0] rem;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(int r, int d, int s, int p, int per, int ar,
                                int t, int b, int dn, int rem);
        vec_t v;
        v.rst   = r[0];
        v.div   = d[0];
        v.start = s[0];
        v.stop  = p[0];
        v.per   = per[7:0];
        v.ar    = ar[0];
        v.tick  = t[0];
        v.busy  = b[0];
        v.done  = dn[0];
        v.rem   = rem[7:0];
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic wave(int c);
        return ((c % 8) < 4);
    endfunction

    int tick_n;
    int done_n;
    int last_done;

    initial begin
        // rst div start stop per ar | tick busy done rem
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); // no false tick after reset
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0); // zero period -> done only
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 0, 5, 0, 0, 1, 0, 5);
        vecs[7]  = mk(0, 1, 0, 0, 5, 0, 1, 1, 0, 4);
        vecs[8]  = mk(0, 0, 0, 0, 5, 0, 0, 1, 0, 4);
        vecs[9]  = mk(0, 1, 0, 0, 5, 0, 1, 1, 0, 3);
        vecs[10] = mk(0, 0, 0, 0, 5, 0, 0, 1, 0, 3);
        vecs[11] = mk(0, 1, 0, 0, 5, 0, 1, 1, 0, 2);
        vecs[12] = mk(0, 0, 0, 0, 5, 0, 0, 1, 0, 2);
        vecs[13] = mk(0, 1, 1, 0, 5, 0, 1, 1, 0, 5); // restart beats coincident rise
        vecs[14] = mk(0, 0, 0, 0, 5, 0, 0, 1, 0, 5);
        vecs[15] = mk(0, 1, 0, 0, 5, 0, 1, 1, 0, 4);
        vecs[16] = mk(0, 0, 0, 1, 5, 0, 0, 0, 0, 0); // abort, no done
        vecs[17] = mk(0, 1, 0, 0, 5, 0, 1, 0, 0, 0); // idle tick only
        vecs[18] = mk(0, 0, 1, 0, 3, 0, 0, 1, 0, 3);
        vecs[19] = mk(0, 1, 1, 1, 7, 0, 1, 1, 0, 7); // start beats stop
        vecs[20] = mk(0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        vecs[21] = mk(0, 1, 1, 0, 1, 0, 1, 1, 0, 1);
        vecs[22] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
        vecs[23] = mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 0); // single-shot expiry
        vecs[24] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            rst         = vecs[i].rst;
            div_in      = vecs[i].div;
            start       = vecs[i].start;
            stop        = vecs[i].stop;
            period      = vecs[i].per;
            auto_reload = vecs[i].ar;
            step();
            chk($sformatf("vec%0d tick", i), int'(tick), int'(vecs[i].tick));
            chk($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].busy));
            chk($sformatf("vec%0d done", i), int'(done), int'(vecs[i].done));
            chk($sformatf("vec%0d remaining", i), int'(remaining), int'(vecs[i].rem));
        end
        stop = 1'b0;

        // Single-shot, period 3, 8-cycle square wave.
        div_in = 1'b0; start = 1'b1; period = 8'd3; auto_reload = 1'b0;
        step();
        start = 1'b0;
        chk("ss_start busy", int'(busy), 1);
        chk("ss_start remaining", int'(remaining), 3);
        tick_n = 0; done_n = 0;
        for (int c = 0; c < 40; c++) begin
            div_in = wave(c);
            step();
            if (tick) begin
                tick_n++;
                if (tick_n <= 3) begin
                    chk($sformatf("ss tick%0d remaining", tick_n), int'(remaining), 3 - tick_n);
                    chk($sformatf("ss tick%0d done", tick_n), int'(done), (tick_n == 3) ? 1 : 0);
                    chk($sformatf("ss tick%0d busy", tick_n), int'(busy), (tick_n < 3) ? 1 : 0);
                end else begin
                    chk("ss idle remaining", int'(remaining), 0);
                end
            end else begin
                chk("ss no done off-tick", int'(done), 0);
            end
            if (done) done_n++;
        end
        chk("ss tick count", tick_n, 5);
        chk("ss done count", done_n, 1);

        // Auto-reload, period 2: done every 16 cycles, busy held.
        div_in = 1'b0; start = 1'b1; period = 8'd2; auto_reload = 1'b1;
        step();
        start = 1'b0;
        chk("ar_start remaining", int'(remaining), 2);
        tick_n = 0; done_n = 0; last_done = -1;
        for (int c = 0; c < 48; c++) begin
            div_in = wave(c);
            step();
            chk("ar busy", int'(busy), 1);
            if (tick) begin
                tick_n++;
                chk($sformatf("ar tick%0d remaining", tick_n), int'(remaining),
                    (tick_n % 2 == 1) ? 1 : 2);
                chk($sformatf("ar tick%0d done", tick_n), int'(done),
                    (tick_n % 2 == 0) ? 1 : 0);
            end
            if (done) begin
                done_n++;
                if (last_done >= 0) chk("ar done spacing", c - last_done, 16);
                last_done = c;
            end
        end
        chk("ar done count", done_n, 3);
        auto_reload = 1'b0;

        // Reset mid-run with remaining = 4.
        div_in = 1'b0; start = 1'b1; period = 8'd6;
        step();
        start = 1'b0;
        div_in = 1'b1; step();
        div_in = 1'b0; step();
        div_in = 1'b1; step();
        div_in = 1'b0; step();
        chk("rst_mid pre remaining", int'(remaining), 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid busy", int'(busy), 0);
        chk("rst_mid remaining", int'(remaining), 0);
        chk("rst_mid done", int'(done), 0);
        tick_n = 0; done_n = 0;
        for (int c = 0; c < 32; c++) begin
            div_in = wave(c);
            step();
            if (tick) tick_n++;
            if (done) done_n++;
            if (busy || remaining != 0) done_n += 100;
        end
        chk("rst_mid later ticks", tick_n, 4);
        chk("rst_mid no done/busy after", done_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
